uart_fifo_bridge: RTL

//  Memory-mapped front end between the RV32IM core data bus and the uart block. Buffers

---
 rtl/uart_fifo_bridge.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/uart_fifo_bridge.sv
// Memory-mapped bridge between the core data bus and the uart block.
// TX/RX byte FIFOs, a TX drain sequencer and a level interrupt.
module uart_fifo_bridge #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned FIFO_AW    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_valid,
  input  logic        bus_we,
  input  logic [3:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_ready,
  output logic        uart_tx_start,
  output logic [7:0]  uart_tx_data,
  input  logic        uart_tx_busy,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_ready,
  output logic        irq
);
  localparam int unsigned CW = FIFO_AW + 1;
  localparam logic [3:0] ADDR_DATA = 4'h0;
  localparam logic [3:0] ADDR_STAT = 4'h4;
  localparam logic [3:0] ADDR_CTRL = 4'h8;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_WAIT_BUSY, TX_WAIT_DONE} tx_state_e;

  tx_state_e          tx_state_q;
  logic [7:0]         tx_mem_q [FIFO_DEPTH];
  logic [7:0]         rx_mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0] tx_wr_q, tx_rd_q, rx_wr_q, rx_rd_q;
  logic [CW-1:0]      tx_cnt_q, rx_cnt_q, tx_cnt_d, rx_cnt_d;
  logic               tx_ovf_q, rx_ovf_q, tx_ovf_d, rx_ovf_d;
  logic [1:0]         ctrl_q;
  logic [31:0]        bus_rdata_q, rdata_d;
  logic               bus_ready_q, tx_start_q, irq_q, irq_d;
  logic [7:0]         tx_data_q;

  logic acc_data, acc_stat, acc_ctrl;
  logic tx_full, tx_empty, rx_full, rx_empty, tx_idle;
  logic tx_push_req, tx_push, tx_pop, rx_push, rx_pop;
  logic [31:0] status;
  logic unused_wdata;

  assign acc_data = bus_valid && (bus_addr == ADDR_DATA);
  assign acc_stat = bus_valid && (bus_addr == ADDR_STAT);
  assign acc_ctrl = bus_valid && (bus_addr == ADDR_CTRL);

  assign tx_full  = (tx_cnt_q == CW'(FIFO_DEPTH));
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == CW'(FIFO_DEPTH));
  assign rx_empty = (rx_cnt_q == '0);
  assign tx_idle  = (tx_state_q == TX_IDLE);

  // A push into a full FIFO is accepted when the same cycle also pops.
  assign tx_pop      = tx_idle && !tx_empty && !uart_tx_busy;
  assign tx_push_req = acc_data && bus_we;
  assign tx_push     = tx_push_req && (!tx_full || tx_pop);
  assign rx_pop      = acc_data && !bus_we && !rx_empty;
  assign rx_push     = uart_rx_ready && (!rx_full || rx_pop);

  assign tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
  assign rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);

  // Sticky overflow flags: a new drop wins over a same-cycle W1C.
  assign tx_ovf_d = (tx_ovf_q && !(acc_stat && bus_we && bus_wdata[4])) ||
                    (tx_push_req && !tx_push);
  assign rx_ovf_d = (rx_ovf_q && !(acc_stat && bus_we && bus_wdata[5])) ||
                    (uart_rx_ready && !rx_push);

  assign irq_d = (ctrl_q[0] && !rx_empty) || (ctrl_q[1] && tx_empty && tx_idle);

  assign status = {8'h00, 8'(tx_cnt_q), 8'(rx_cnt_q), 1'b0, tx_idle, rx_ovf_q, tx_ovf_q,
                   rx_empty, rx_full, tx_empty, tx_full};

  assign unused_wdata = ^bus_wdata[31:8];

  always_comb begin
    rdata_d = '0;
    if (bus_valid && !bus_we) begin
      case (bus_addr)
        ADDR_DATA: if (!rx_empty) rdata_d = {23'b0, 1'b1, rx_mem_q[rx_rd_q]};
        ADDR_STAT: rdata_d = status;
        ADDR_CTRL: rdata_d = {30'b0, ctrl_q};
        default:   rdata_d = '0;
      endcase
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by the counters.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wr_q] <= bus_wdata[7:0];
    if (rx_push) rx_mem_q[rx_wr_q] <= uart_rx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q  <= TX_IDLE;
      tx_wr_q     <= '0;
      tx_rd_q     <= '0;
      rx_wr_q     <= '0;
      rx_rd_q     <= '0;
      tx_cnt_q    <= '0;
      rx_cnt_q    <= '0;
      tx_ovf_q    <= 1'b0;
      rx_ovf_q    <= 1'b0;
      ctrl_q      <= '0;
      bus_rdata_q <= '0;
      bus_ready_q <= 1'b0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      irq_q       <= 1'b0;
    end else begin
      bus_ready_q <= bus_valid;
      bus_rdata_q <= rdata_d;
      irq_q       <= irq_d;
      tx_cnt_q    <= tx_cnt_d;
      rx_cnt_q    <= rx_cnt_d;
      tx_ovf_q    <= tx_ovf_d;
      rx_ovf_q    <= rx_ovf_d;
      if (tx_push) tx_wr_q <= tx_wr_q + FIFO_AW'(1);
      if (tx_pop)  tx_rd_q <= tx_rd_q + FIFO_AW'(1);
      if (rx_push) rx_wr_q <= rx_wr_q + FIFO_AW'(1);
      if (rx_pop)  rx_rd_q <= rx_rd_q + FIFO_AW'(1);
      if (acc_ctrl && bus_we) ctrl_q <= bus_wdata[1:0];

      // One byte in flight: launch, see busy rise, then wait for it to fall.
      tx_start_q <= 1'b0;
      case (tx_state_q)
        TX_IDLE: begin
          if (tx_pop) begin
            tx_data_q  <= tx_mem_q[tx_rd_q];
            tx_start_q <= 1'b1;
            tx_state_q <= TX_START;
          end
        end
        TX_START:     tx_state_q <= TX_WAIT_BUSY;
        TX_WAIT_BUSY: if (uart_tx_busy) tx_state_q <= TX_WAIT_DONE;
        TX_WAIT_DONE: if (!uart_tx_busy) tx_state_q <= TX_IDLE;
        default:      tx_state_q <= TX_IDLE;
      endcase
    end
  end

  assign bus_rdata     = bus_rdata_q;
  assign bus_ready     = bus_ready_q;
  assign uart_tx_start = tx_start_q;
  assign uart_tx_data  = tx_data_q;
  assign irq           = irq_q;
endmodule
